// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures the decoded control bundle and operands for the EX stage,
// with stall (hold), flush (bubble insertion) and a saturating count of inserted bubbles.
module id_ex_pipe_reg #(
   parameter int         XLEN      = 32,
   parameter logic [2:0] B_DISABLE = 3'b010,
   parameter logic [1:0] J_DISABLE = 2'b00,
   parameter int         CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             flush,
   input  logic             valid_d,
   input  logic             reg_write_d,
   input  logic [1:0]       result_src_d,
   input  logic             mem_write_d,
   input  logic [1:0]       jump_d,
   input  logic [2:0]       branch_d,
   input  logic [2:0]       alu_ctrl_d,
   input  logic             alu_src_d,
   input  logic [XLEN-1:0]  rd1_d,
   input  logic [XLEN-1:0]  rd2_d,
   input  logic [XLEN-1:0]  imm_ext_d,
   input  logic [XLEN-1:0]  pc_d,
   input  logic [XLEN-1:0]  pc_plus4_d,
   input  logic [4:0]       rs1_d,
   input  logic [4:0]       rs2_d,
   input  logic [4:0]       rd_d,
   output logic             valid_e,
   output logic             reg_write_e,
   output logic [1:0]       result_src_e,
   output logic             mem_write_e,
   output logic [1:0]       jump_e,
   output logic [2:0]       branch_e,
   output logic [2:0]       alu_ctrl_e,
   output logic             alu_src_e,
   output logic [XLEN-1:0]  rd1_e,
   output logic [XLEN-1:0]  rd2_e,
   output logic [XLEN-1:0]  imm_ext_e,
   output logic [XLEN-1:0]  pc_e,
   output logic [XLEN-1:0]  pc_plus4_e,
   output logic [4:0]       rs1_e,
   output logic [4:0]       rs2_e,
   output logic [4:0]       rd_e,
   output logic [CNT_W-1:0] bubble_cnt
);

   typedef struct packed {
      logic            valid;
      logic            reg_write;
      logic [1:0]      result_src;
      logic            mem_write;
      logic [1:0]      jump;
      logic [2:0]      branch;
      logic [2:0]      alu_ctrl;
      logic            alu_src;
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] imm_ext;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
   } ex_bundle_t;

   ex_bundle_t       ex_q, ex_d, in_s;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // A bubble is also the reset image: every field zero except the "no branch/no jump" codes.
   function automatic ex_bundle_t bubble();
      ex_bundle_t b;
      b        = '0;
      b.branch = B_DISABLE;
      b.jump   = J_DISABLE;
      return b;
   endfunction

   // Gather the decode-side inputs into one bundle.
   always_comb begin
      in_s            = '0;
      in_s.valid      = valid_d;
      in_s.reg_write  = reg_write_d;
      in_s.result_src = result_src_d;
      in_s.mem_write  = mem_write_d;
      in_s.jump       = jump_d;
      in_s.branch     = branch_d;
      in_s.alu_ctrl   = alu_ctrl_d;
      in_s.alu_src    = alu_src_d;
      in_s.rd1        = rd1_d;
      in_s.rd2        = rd2_d;
      in_s.imm_ext    = imm_ext_d;
      in_s.pc         = pc_d;
      in_s.pc_plus4   = pc_plus4_d;
      in_s.rs1        = rs1_d;
      in_s.rs2        = rs2_d;
      in_s.rd         = rd_d;
   end

   // Next-state selection: flush beats stall beats a normal load.
   always_comb begin
      ex_d  = ex_q;
      cnt_d = cnt_q;
      if (flush) begin
         ex_d = bubble();
         if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            cnt_d = cnt_q;
         end
      end else if (stall) begin
         ex_d = ex_q;
      end else begin
         ex_d = in_s;
         // An empty slot still carries its fields but must not touch architectural state.
         if (!valid_d) begin
            ex_d.reg_write = 1'b0;
            ex_d.mem_write = 1'b0;
            ex_d.jump      = J_DISABLE;
            ex_d.branch    = B_DISABLE;
         end else begin
            ex_d.reg_write = reg_write_d;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q  <= bubble();
         cnt_q <= '0;
      end else begin
         ex_q  <= ex_d;
         cnt_q <= cnt_d;
      end
   end

   assign valid_e      = ex_q.valid;
   assign reg_write_e  = ex_q.reg_write;
   assign result_src_e = ex_q.result_src;
   assign mem_write_e  = ex_q.mem_write;
   assign jump_e       = ex_q.jump;
   assign branch_e     = ex_q.branch;
   assign alu_ctrl_e   = ex_q.alu_ctrl;
   assign alu_src_e    = ex_q.alu_src;
   assign rd1_e        = ex_q.rd1;
   assign rd2_e        = ex_q.rd2;
   assign imm_ext_e    = ex_q.imm_ext;
   assign pc_e         = ex_q.pc;
   assign pc_plus4_e   = ex_q.pc_plus4;
   assign rs1_e        = ex_q.rs1;
   assign rs2_e        = ex_q.rs2;
   assign rd_e         = ex_q.rd;
   assign bubble_cnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed steps then random traffic against a reference model.
// A second instance with a 2-bit bubble counter exercises saturation.
module tb_id_ex_pipe_reg;

   logic clk = 1'b0;
   logic rst, stall, flush;
   logic valid_d, reg_write_d, mem_write_d, alu_src_d;
   logic [1:0]  result_src_d, jump_d;
   logic [2:0]  branch_d, alu_ctrl_d;
   logic [31:0] rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d;
   logic [4:0]  rs1_d, rs2_d, rd_d;

   logic valid_e, reg_write_e, mem_write_e, alu_src_e;
   logic [1:0]  result_src_e, jump_e;
   logic [2:0]  branch_e, alu_ctrl_e;
   logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e;
   logic [4:0]  rs1_e, rs2_e, rd_e;
   logic [15:0] bubble_cnt;

   logic s_valid_e, s_reg_write_e, s_mem_write_e, s_alu_src_e;
   logic [1:0]  s_result_src_e, s_jump_e;
   logic [2:0]  s_branch_e, s_alu_ctrl_e;
   logic [31:0] s_rd1_e, s_rd2_e, s_imm_ext_e, s_pc_e, s_pc_plus4_e;
   logic [4:0]  s_rs1_e, s_rs2_e, s_rd_e;
   logic [1:0]  s_bubble_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   id_ex_pipe_reg #(.XLEN(32), .B_DISABLE(3'b010), .J_DISABLE(2'b00), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_d(valid_d),
      .reg_write_d(reg_write_d), .result_src_d(result_src_d), .mem_write_d(mem_write_d),
      .jump_d(jump_d), .branch_d(branch_d), .alu_ctrl_d(alu_ctrl_d), .alu_src_d(alu_src_d),
      .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_ext_d(imm_ext_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
      .valid_e(valid_e), .reg_write_e(reg_write_e), .result_src_e(result_src_e),
      .mem_write_e(mem_write_e), .jump_e(jump_e), .branch_e(branch_e), .alu_ctrl_e(alu_ctrl_e),
      .alu_src_e(alu_src_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_ext_e(imm_ext_e), .pc_e(pc_e),
      .pc_plus4_e(pc_plus4_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .bubble_cnt(bubble_cnt)
   );

   id_ex_pipe_reg #(.XLEN(32), .B_DISABLE(3'b010), .J_DISABLE(2'b00), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_d(valid_d),
      .reg_write_d(reg_write_d), .result_src_d(result_src_d), .mem_write_d(mem_write_d),
      .jump_d(jump_d), .branch_d(branch_d), .alu_ctrl_d(alu_ctrl_d), .alu_src_d(alu_src_d),
      .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_ext_d(imm_ext_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
      .valid_e(s_valid_e), .reg_write_e(s_reg_write_e), .result_src_e(s_result_src_e),
      .mem_write_e(s_mem_write_e), .jump_e(s_jump_e), .branch_e(s_branch_e),
      .alu_ctrl_e(s_alu_ctrl_e), .alu_src_e(s_alu_src_e), .rd1_e(s_rd1_e), .rd2_e(s_rd2_e),
      .imm_ext_e(s_imm_ext_e), .pc_e(s_pc_e), .pc_plus4_e(s_pc_plus4_e), .rs1_e(s_rs1_e),
      .rs2_e(s_rs2_e), .rd_e(s_rd_e), .bubble_cnt(s_bubble_cnt)
   );

   // Reference model: what EX should hold, kept as one flat record.
   typedef struct packed {
      logic        valid, reg_write;
      logic [1:0]  result_src;
      logic        mem_write;
      logic [1:0]  jump;
      logic [2:0]  branch, alu_ctrl;
      logic        alu_src;
      logic [31:0] rd1, rd2, imm, pc, pc4;
      logic [4:0]  rs1, rs2, rd;
   } ex_t;

   ex_t m;
   int  m_cnt16 = 0;
   int  m_cnt2  = 0;

   function automatic ex_t empty_slot();
      ex_t e;
      e = '0;
      e.branch = 3'b010;
      e.jump   = 2'b00;
      return e;
   endfunction

   task automatic model_edge();
      if (rst) begin
         m = empty_slot(); m_cnt16 = 0; m_cnt2 = 0;
      end else if (flush) begin
         m = empty_slot();
         m_cnt16 = (m_cnt16 == 65535) ? 65535 : m_cnt16 + 1;
         m_cnt2  = (m_cnt2 == 3) ? 3 : m_cnt2 + 1;
      end else if (!stall) begin
         m = '{valid_d, reg_write_d, result_src_d, mem_write_d, jump_d, branch_d, alu_ctrl_d,
               alu_src_d, rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d, rs1_d, rs2_d, rd_d};
         if (!valid_d) begin
            m.reg_write = 1'b0; m.mem_write = 1'b0; m.jump = 2'b00; m.branch = 3'b010;
         end
      end
   endtask

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("valid_e", 256'(valid_e), 256'(m.valid));
      check("reg_write_e", 256'(reg_write_e), 256'(m.reg_write));
      check("result_src_e", 256'(result_src_e), 256'(m.result_src));
      check("mem_write_e", 256'(mem_write_e), 256'(m.mem_write));
      check("jump_e", 256'(jump_e), 256'(m.jump));
      check("branch_e", 256'(branch_e), 256'(m.branch));
      check("alu_ctrl_e", 256'(alu_ctrl_e), 256'(m.alu_ctrl));
      check("alu_src_e", 256'(alu_src_e), 256'(m.alu_src));
      check("rd1_e", 256'(rd1_e), 256'(m.rd1));
      check("rd2_e", 256'(rd2_e), 256'(m.rd2));
      check("imm_ext_e", 256'(imm_ext_e), 256'(m.imm));
      check("pc_e", 256'(pc_e), 256'(m.pc));
      check("pc_plus4_e", 256'(pc_plus4_e), 256'(m.pc4));
      check("rs1_e", 256'(rs1_e), 256'(m.rs1));
      check("rs2_e", 256'(rs2_e), 256'(m.rs2));
      check("rd_e", 256'(rd_e), 256'(m.rd));
      check("bubble_cnt", 256'(bubble_cnt), 256'(m_cnt16));
      check("sat_bubble_cnt", 256'(s_bubble_cnt), 256'(m_cnt2));
      check("sat_bundle", 256'({s_valid_e, s_reg_write_e, s_result_src_e, s_mem_write_e, s_jump_e,
            s_branch_e, s_alu_ctrl_e, s_alu_src_e, s_rd1_e, s_rd2_e, s_imm_ext_e, s_pc_e,
            s_pc_plus4_e, s_rs1_e, s_rs2_e, s_rd_e}), 256'(m));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic randomize_d();
      valid_d      = ($urandom_range(3) != 0);
      reg_write_d  = 1'($urandom);
      result_src_d = 2'($urandom);
      mem_write_d  = 1'($urandom);
      jump_d       = 2'($urandom);
      branch_d     = 3'($urandom);
      alu_ctrl_d   = 3'($urandom);
      alu_src_d    = 1'($urandom);
      rd1_d = $urandom; rd2_d = $urandom; imm_ext_d = $urandom;
      pc_d  = $urandom; pc_plus4_d = pc_d + 32'd4;
      rs1_d = 5'($urandom); rs2_d = 5'($urandom); rd_d = 5'($urandom);
   endtask

   initial begin
      logic [15:0] saved_cnt;
      int sat_seq [5] = '{1, 2, 3, 3, 3};
      m = empty_slot();

      // Reset held for two cycles.
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      randomize_d();
      step(); step();
      check("rst_branch", 256'(branch_e), 256'(3'b010));
      check("rst_cnt", 256'(bubble_cnt), 256'(16'd0));
      check("rst_valid", 256'(valid_e), 256'(1'b0));
      rst = 1'b0;

      // add x5 with rd1 = 0x10.
      randomize_d();
      valid_d = 1'b1; reg_write_d = 1'b1; alu_ctrl_d = 3'b000; rd_d = 5'd5; rd1_d = 32'h10;
      step();
      check("add_reg_write", 256'(reg_write_e), 256'(1'b1));
      check("add_rd", 256'(rd_e), 256'(5'd5));
      check("add_rd1", 256'(rd1_e), 256'(32'h10));

      // beq, then three stalled cycles with changing inputs.
      randomize_d();
      valid_d = 1'b1; branch_d = 3'b000;
      step();
      saved_cnt = bubble_cnt;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         randomize_d();
         step();
         check("stall_branch", 256'(branch_e), 256'(3'b000));
         check("stall_cnt", 256'(bubble_cnt), 256'(saved_cnt));
      end

      // sw with flush and stall together.
      randomize_d();
      valid_d = 1'b1; mem_write_d = 1'b1; flush = 1'b1;
      step();
      check("flush_mem_write", 256'(mem_write_e), 256'(1'b0));
      check("flush_valid", 256'(valid_e), 256'(1'b0));
      check("flush_branch", 256'(branch_e), 256'(3'b010));
      check("flush_cnt", 256'(bubble_cnt), 256'(saved_cnt + 16'd1));
      flush = 1'b0; stall = 1'b0;

      // 2-bit counter saturation from a fresh reset.
      rst = 1'b1; step(); rst = 1'b0;
      flush = 1'b1;
      for (int i = 0; i < 5; i++) begin
         randomize_d();
         step();
         check("sat_seq", 256'(s_bubble_cnt), 256'(sat_seq[i]));
      end
      flush = 1'b0;

      // jal in an empty slot.
      randomize_d();
      valid_d = 1'b0; jump_d = 2'b01; reg_write_d = 1'b1; pc_d = 32'h0000_1234;
      step();
      check("jal_jump", 256'(jump_e), 256'(2'b00));
      check("jal_reg_write", 256'(reg_write_e), 256'(1'b0));
      check("jal_pc", 256'(pc_e), 256'(32'h0000_1234));

      // Reset while stalled and flushing.
      stall = 1'b1; flush = 1'b1; rst = 1'b1;
      step();
      rst = 1'b0; flush = 1'b0; stall = 1'b0;

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         randomize_d();
         rst   = ($urandom_range(39) == 0);
         flush = ($urandom_range(5) == 0);
         stall = ($urandom_range(3) == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
